ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 150 +++++++++++++++
 tb/tb_ifetch_unit.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ifetch_unit                                                   |
// | Purpose  : Single-outstanding instruction fetch unit. Requests one word  |
// |            at pc, waits for the response, holds it for the core until   |
// |            it is consumed, then selects the next PC or halts.           |
// | Ports    : clk, rst_n             - clock, async active-low reset        |
// |            imem_req/addr/gnt      - instruction memory request channel  |
// |            imem_rvalid/rdata      - instruction memory response channel |
// |            inst_valid/inst/pc/pc4 - instruction presented to the core   |
// |            inst_ready             - core consumes the held instruction  |
// |            npc_op/imm/alu_c/pc_en - next-PC controls from the decoder   |
// |            halted/fetch_err       - fetch stopped / stopped on misalign |
// |            instret                - consumed-instruction counter        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ifetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   input  logic        inst_ready,
   input  logic [1:0]  npc_op,
   input  logic [31:0] imm,
   input  logic [31:0] alu_c,
   input  logic        pc_en,
   output logic        halted,
   output logic        fetch_err,
   output logic [31:0] instret
);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_HOLD  = 2'd2,
      S_HALT  = 2'd3
   } state_t;

   localparam logic [1:0] NPC_PC4 = 2'b00;
   localparam logic [1:0] NPC_ADD = 2'b01;
   localparam logic [1:0] NPC_ALU = 2'b10;

   state_t      state_q;
   state_t      state_d;
   logic [31:0] pc_q;
   logic [31:0] inst_q;
   logic [31:0] instret_q;
   logic        fetch_err_q;
   logic [31:0] next_pc;
   logic        consume;
   logic        misaligned;
   logic        stop;

   // Next-PC selection; the reserved encoding falls back to sequential flow.
   always_comb begin
      next_pc = pc_q + 32'd4;
      case (npc_op)
         NPC_PC4: next_pc = pc_q + 32'd4;
         NPC_ADD: next_pc = pc_q + imm;
         NPC_ALU: next_pc = {alu_c[31:1], 1'b0};
         default: next_pc = pc_q + 32'd4;
      endcase
   end

   assign consume    = (state_q == S_HOLD) && inst_ready;
   assign misaligned = (next_pc[1:0] != 2'b00);
   // Halt either on an explicit halt instruction or on an unfetchable target.
   assign stop       = !pc_en || misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      case (state_q)
         S_FETCH: begin
            // Gate with rst_n so the request drops as soon as reset asserts.
            imem_req = rst_n;
            if (imem_gnt) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               state_d = S_HOLD;
            end
         end
         S_HOLD: begin
            inst_valid = 1'b1;
            if (inst_ready) begin
               state_d = stop ? S_HALT : S_FETCH;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q        <= RESET_PC;
         inst_q      <= 32'd0;
         instret_q   <= 32'd0;
         fetch_err_q <= 1'b0;
      end else begin
         if ((state_q == S_WAIT) && imem_rvalid) begin
            inst_q <= imem_rdata;
         end
         if (consume) begin
            instret_q <= instret_q + 32'd1;
            if (pc_en && !misaligned) begin
               pc_q <= next_pc;
            end
            if (pc_en && misaligned) begin
               fetch_err_q <= 1'b1;
            end
         end
      end
   end

   assign imem_addr = pc_q;
   assign pc        = pc_q;
   assign pc4       = pc_q + 32'd4;
   assign inst      = inst_q;
   assign halted    = (state_q == S_HALT);
   assign fetch_err = fetch_err_q;
   assign instret   = instret_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ifetch_unit                                                |
// | Purpose  : Self-checking bench for ifetch_unit. A small memory/core     |
// |            driver pushes each granted instruction word into a queue and |
// |            compares it when the unit presents it; a PC/instret model    |
// |            predicts the next fetch address and halt status.            |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ifetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = 32'd0;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] pc;
   logic [31:0] pc4;
   logic        inst_ready = 1'b0;
   logic [1:0]  npc_op = 2'b00;
   logic [31:0] imm = 32'd0;
   logic [31:0] alu_c = 32'd0;
   logic        pc_en = 1'b1;
   logic        halted;
   logic        fetch_err;
   logic [31:0] instret;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] sb_q[$];
   logic [31:0] exp_pc;
   logic [31:0] exp_instret;
   logic        exp_halt;
   logic        exp_err;

   ifetch_unit #(.RESET_PC(RESET_PC)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .pc         (pc),
      .pc4        (pc4),
      .inst_ready (inst_ready),
      .npc_op     (npc_op),
      .imm        (imm),
      .alu_c      (alu_c),
      .pc_en      (pc_en),
      .halted     (halted),
      .fetch_err  (fetch_err),
      .instret    (instret)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_req"},     {31'd0, imem_req},   32'd0);
      check({tag, "_pc"},      pc,                  RESET_PC);
      check({tag, "_inst"},    inst,                32'd0);
      check({tag, "_ivalid"},  {31'd0, inst_valid}, 32'd0);
      check({tag, "_halted"},  {31'd0, halted},     32'd0);
      check({tag, "_err"},     {31'd0, fetch_err},  32'd0);
      check({tag, "_instret"}, instret,             32'd0);
   endtask

   // One full fetch/consume transaction. Entered just after a falling edge
   // with the unit expected in FETCH; leaves just after a falling edge.
   task automatic run_inst(input int gd, input int rd, input int hd,
                           input logic [1:0] op, input logic [31:0] im,
                           input logic [31:0] alu, input logic en,
                           input logic [31:0] word);
      logic [31:0] npc;
      logic [31:0] held_exp;
      check("req", {31'd0, imem_req}, 32'd1);
      check("addr", imem_addr, exp_pc);
      // Grant stall: rvalid and inst_ready are driven but must be ignored.
      for (int i = 0; i < gd; i++) begin
         imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; inst_ready = 1'b1;
         tick();
         check("stall_req", {31'd0, imem_req}, 32'd1);
         check("stall_addr", imem_addr, exp_pc);
      end
      imem_rvalid = 1'b0; inst_ready = 1'b1; imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      sb_q.push_back(word);
      check("wait_req", {31'd0, imem_req}, 32'd0);
      for (int i = 0; i < rd; i++) begin
         imem_gnt = 1'b1;  // no second request may be issued while waiting
         tick();
         check("no_dup_req", {31'd0, imem_req}, 32'd0);
         check("wait_ivalid", {31'd0, inst_valid}, 32'd0);
      end
      imem_gnt = 1'b0; inst_ready = 1'b0;
      imem_rvalid = 1'b1; imem_rdata = word;
      tick();
      imem_rvalid = 1'b0; imem_rdata = $urandom;
      check("hold_ivalid", {31'd0, inst_valid}, 32'd1);
      if (sb_q.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         held_exp = 32'd0;
      end else begin
         held_exp = sb_q.pop_front();
      end
      check("inst", inst, held_exp);
      check("pc", pc, exp_pc);
      check("pc4", pc4, exp_pc + 32'd4);
      for (int i = 0; i < hd; i++) begin
         npc_op = 2'($urandom_range(0, 3)); pc_en = 1'($urandom_range(0, 1));
         tick();
         check("held_ivalid", {31'd0, inst_valid}, 32'd1);
         check("held_inst", inst, held_exp);
         check("held_pc", pc, exp_pc);
         check("held_instret", instret, exp_instret);
      end
      inst_ready = 1'b1; npc_op = op; imm = im; alu_c = alu; pc_en = en;
      tick();
      inst_ready = 1'b0; pc_en = 1'b1;
      // Reference next-PC model.
      case (op)
         2'b01:   npc = exp_pc + im;
         2'b10:   npc = alu & 32'hFFFF_FFFE;
         default: npc = exp_pc + 32'd4;
      endcase
      exp_instret = exp_instret + 32'd1;
      if (!en) begin
         exp_halt = 1'b1;
      end else if (npc[1:0] != 2'b00) begin
         exp_halt = 1'b1; exp_err = 1'b1;
      end else begin
         exp_pc = npc;
      end
      check("instret", instret, exp_instret);
      check("post_ivalid", {31'd0, inst_valid}, 32'd0);
      check("post_halted", {31'd0, halted}, {31'd0, exp_halt});
      check("post_err", {31'd0, fetch_err}, {31'd0, exp_err});
      check("post_req", {31'd0, imem_req}, {31'd0, !exp_halt});
      check("post_pc", pc, exp_pc);
   endtask

   task automatic check_halt_stays(input int n);
      for (int i = 0; i < n; i++) begin
         imem_gnt = 1'b1; imem_rvalid = 1'b1; inst_ready = 1'b1;
         tick();
         check("halt_req", {31'd0, imem_req}, 32'd0);
         check("halt_ivalid", {31'd0, inst_valid}, 32'd0);
         check("halt_flag", {31'd0, halted}, 32'd1);
         check("halt_pc", pc, exp_pc);
      end
      imem_gnt = 1'b0; imem_rvalid = 1'b0; inst_ready = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      check_reset_values("rst_async");
      tick();
      tick();
      check_reset_values("rst_held");
      sb_q.delete();
      exp_pc = RESET_PC; exp_instret = 32'd0; exp_halt = 1'b0; exp_err = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rel_req", {31'd0, imem_req}, 32'd1);
   endtask

   initial begin
      exp_pc = RESET_PC; exp_instret = 32'd0; exp_halt = 1'b0; exp_err = 1'b0;
      tick();
      do_reset();

      // Basic sequential fetch at minimum latency.
      run_inst(0, 0, 0, 2'b00, 32'd0, 32'd0, 1'b1, 32'h0050_0093);
      // Relative jump to 0x100, then backwards by 16.
      run_inst(0, 0, 0, 2'b01, 32'h0000_00FC, 32'd0, 1'b1, 32'h0FC0_006F);
      run_inst(0, 0, 0, 2'b01, 32'hFFFF_FFF0, 32'd0, 1'b1, 32'hFF1F_F06F);
      // Register jump clears bit0.
      run_inst(0, 0, 0, 2'b10, 32'd0, 32'h0000_2001, 1'b1, 32'h0000_8067);
      // Stalls on every handshake.
      run_inst(5, 3, 4, 2'b00, 32'd0, 32'd0, 1'b1, 32'h1234_5678);
      // Reserved encoding behaves as pc+4.
      run_inst(1, 1, 1, 2'b11, 32'h0000_0100, 32'h0000_4000, 1'b1, 32'hCAFE_F00D);
      // Misaligned register target halts with an error, pc unchanged.
      run_inst(0, 2, 0, 2'b10, 32'd0, 32'h0000_2002, 1'b1, 32'h0001_0067);
      check_halt_stays(4);

      // Halt instruction plus instret wrap from all-ones.
      do_reset();
      run_inst(0, 0, 0, 2'b00, 32'd0, 32'd0, 1'b1, 32'h0000_0013);
      dut.instret_q = 32'hFFFF_FFFF;
      exp_instret = 32'hFFFF_FFFF;
      run_inst(0, 0, 2, 2'b01, 32'h0000_0040, 32'd0, 1'b0, 32'h0010_0073);
      check("wrap_instret", instret, 32'd0);
      check_halt_stays(3);

      // Reset in the middle of WAIT discards the outstanding request.
      do_reset();
      run_inst(0, 0, 0, 2'b00, 32'd0, 32'd0, 1'b1, 32'h0000_0033);
      imem_gnt = 1'b1;
      tick();
      imem_gnt = 1'b0;
      tick();
      check("midwait_req", {31'd0, imem_req}, 32'd0);
      do_reset();
      run_inst(0, 1, 0, 2'b00, 32'd0, 32'd0, 1'b1, 32'hABCD_0001);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // Global watchdog so the bench always terminates.
   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
